// File: rtl/arb_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
//   N_REQ   - number of requesters
//   ID_W    - width of a requester index
//   state_t - arbiter FSM state
package arb_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned ID_W  = 4;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } state_t;

endpackage

// File: rtl/or16.sv
// 16-input OR reduction.
//   data_i - 16-bit input vector
//   any_o  - high when any bit of data_i is high
module or16 (
  input  logic [15:0] data_i,
  output logic        any_o
);

  assign any_o = |data_i;

endmodule

// File: rtl/arb16_rr.sv
// Round-robin arbiter sharing one resource among 16 requesters.
// A grant is registered and one-hot; it is held until the owner drops its
// request or MAX_HOLD cycles have elapsed (MAX_HOLD = 0 means unlimited).
// Every grant is followed by one IDLE cycle, so handoffs are always clean.
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   req       - level-sensitive request vector, bit i = requester i
//   gnt       - registered one-hot grant, zero when no owner
//   gnt_valid - high while gnt is non-zero
//   gnt_id    - index of the granted requester, 0 when gnt_valid is low
module arb16_rr
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id
);

  localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  // Index of the first set bit searching upward from last+1, wrapping.
  // Rotate so last+1 lands at bit 0, find the lowest set bit, rotate back.
  function automatic logic [ID_W-1:0] pick_next(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  last);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      shamt;
    shamt = {1'b0, last} + 1'b1;
    dbl   = {r, r} >> shamt;
    rot   = dbl[N_REQ-1:0];
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    return last + 1'b1 + off;
  endfunction

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               any_req;
  logic [ID_W-1:0]    next_id;
  logic               hold_expired;

  or16 u_or16 (
    .data_i (req),
    .any_o  (any_req)
  );

  assign next_id      = pick_next(req, last_q);
  assign hold_expired = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = GRANT;
          gnt_d       = N_REQ'(1) << next_id;
          gnt_valid_d = 1'b1;
          gnt_id_d    = next_id;
          last_d      = next_id;
          cnt_d       = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!req[gnt_id_q] || hold_expired) begin
          // last already points at the owner, so a forced-off requester
          // goes to the back of the queue.
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
          cnt_d       = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      last_q      <= ID_W'(N_REQ - 1);
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_arb16_rr.sv
// Self-checking bench for arb16_rr (MAX_HOLD = 4): directed scenarios plus
// random requests, all compared against a behavioural arbiter model.
module tb_arb16_rr;

  localparam int unsigned MaxHold = 4;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] gnt;
  logic        gnt_valid;
  logic [3:0]  gnt_id;

  int n_tests;
  int n_fail;

  // Model: current owner (-1 = none), last grantee, cycles the grant has been visible.
  int m_owner;
  int m_last;
  int m_held;

  arb16_rr #(
    .MAX_HOLD (MaxHold)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 15;
    m_held  = 0;
  endtask

  task automatic model_step(input logic [15:0] r);
    int idx;
    if (m_owner < 0) begin
      if (r != 16'h0) begin
        idx = -1;
        for (int k = 1; k <= 16; k++) begin
          if (idx < 0 && r[(m_last + k) % 16]) idx = (m_last + k) % 16;
        end
        m_owner = idx;
        m_last  = idx;
        m_held  = 1;
      end
    end else if (!r[m_owner] || m_held == int'(MaxHold)) begin
      m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [15:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? 16'h0 : (16'h1 << m_owner);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    check_eq({tag, "_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    check_eq({tag, "_id"}, 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check_eq({tag, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic cycle(input string tag, input logic [15:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    compare_all(tag);
  endtask

  // Asserts reset between clock edges and checks the grant drops without an edge.
  task automatic do_reset(input logic [15:0] r);
    req = r;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst_async");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int order_idx;
    int budget;
    logic [15:0] r;

    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst = 1'b1;
    req = 16'hFFFF;

    // Reset held with all requests asserted.
    repeat (3) begin
      @(negedge clk);
      compare_all("rst_hold");
    end
    rst = 1'b0;
    repeat (5) cycle("idle_noreq", 16'h0000);

    // Single requester.
    cycle("single", 16'h0020);
    check_eq("single_first_id", 32'(gnt_id), 32'd5);
    cycle("single", 16'h0020);
    cycle("single", 16'h0020);
    cycle("single_rel", 16'h0000);
    check_eq("single_released", 32'(gnt), 32'd0);

    // Fairness: each grantee drops its request after 2 cycles of grant.
    do_reset(16'h0000);
    order_idx = 0;
    budget    = 0;
    while (order_idx < 17 && budget < 200) begin
      r = 16'hFFFF;
      if (m_owner >= 0 && m_held == 2) r[m_owner] = 1'b0;
      cycle("rr", r);
      if (m_owner >= 0 && m_held == 1) begin
        check_eq("rr_order", 32'(gnt_id), 32'(order_idx % 16));
        order_idx++;
      end
      budget++;
    end
    check_eq("rr_complete", 32'(order_idx), 32'd17);

    // Wrap-around from last = 14.
    do_reset(16'h0000);
    cycle("wrap_pre", 16'h4000);
    check_eq("wrap_pre_id", 32'(gnt_id), 32'd14);
    cycle("wrap_pre_rel", 16'h0000);
    cycle("wrap", 16'h0009);
    check_eq("wrap_first_id", 32'(gnt_id), 32'd0);
    cycle("wrap", 16'h0008);
    cycle("wrap", 16'h0008);
    check_eq("wrap_second_id", 32'(gnt_id), 32'd3);

    // Forced release with two constant requesters.
    do_reset(16'h0000);
    for (int c = 0; c < 12; c++) begin
      cycle("forced", 16'h0101);
      if (c < 4) check_eq("forced_owner0", 32'(gnt), 32'h0001);
      else if (c == 4 || c == 9) check_eq("forced_gap", 32'(gnt), 32'h0000);
      else if (c < 9) check_eq("forced_owner8", 32'(gnt), 32'h0100);
      else check_eq("forced_owner0_again", 32'(gnt), 32'h0001);
    end

    // Reset mid-grant.
    do_reset(16'h0000);
    cycle("midrst_pre", 16'h0400);
    cycle("midrst_pre", 16'h0400);
    check_eq("midrst_pre_gnt", 32'(gnt), 32'h0400);
    do_reset(16'h0401);
    check_eq("midrst_dropped", 32'(gnt), 32'h0000);
    cycle("midrst_post", 16'h0401);
    check_eq("midrst_post_id", 32'(gnt_id), 32'd0);

    // Random traffic, sometimes sparse so single requesters and idles occur.
    for (int c = 0; c < 400; c++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 9) == 0) r = 16'h0;
      cycle("rand", r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb16_rr.md
# arb16_rr

Round-robin arbiter that shares one resource among 16 requesters. Uses a 16-bit OR reduction of the request vector to detect "any request pending", picks the next requester after the last grantee, and holds a registered one-hot grant until the grantee releases or a hold limit expires. It sits between the requesting units and the shared resource and is the only block that drives the resource's owner select.

## Interface
- MAX_HOLD, default 8: maximum consecutive cycles one grant may be held; 0 = unlimited.
- clk  in  1  clock, all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high; every register is cleared immediately on assertion.
- req  in  16  request vector, bit i = requester i wants the resource; level-sensitive.
- gnt  out  16  one-hot grant, registered; all-zero when no owner.
- gnt_valid  out  1  high while any bit of gnt is high.
- gnt_id  out  4  index of the set gnt bit; 0 when gnt_valid = 0.

## Operation
- States: IDLE, GRANT (2-state FSM, enum in package).
- Reset values: state = IDLE, gnt = 16'h0000, gnt_valid = 0, gnt_id = 0, last pointer = 15 (so index 0 has top priority first), hold counter = 0.
- IDLE: any_req = OR-reduction of req. If any_req = 0, stay IDLE. If any_req = 1, select the first set req bit searching upward from (last+1) mod 16, with wrap 15 -> 0. Load gnt/gnt_id/gnt_valid, set last = selected index, load hold counter = 1, go to GRANT.
- GRANT, owner i:
  - req[i] = 0: release. gnt cleared, go to IDLE.
  - req[i] = 1 and MAX_HOLD != 0 and counter == MAX_HOLD: forced release, same as above. Requester i keeps its request and is served again only after every other pending requester (pointer already past i).
  - Otherwise hold, counter += 1 (saturates; width $clog2(MAX_HOLD+1), minimum 1).
- Requests from non-owners during GRANT are ignored until the next IDLE cycle; no preemption.
- Only one requester pending: it is regranted after release, with the mandatory idle cycle in between.
- A glitch-free one-hot gnt is guaranteed: gnt never has more than one bit set.

## Timing
- Grant latency: req sampled at edge k in IDLE -> gnt valid after edge k (visible in cycle k+1).
- Release latency: req[i] sampled low at edge k -> gnt = 0 after edge k.
- Forced release: gnt high for exactly MAX_HOLD cycles.
- Gap between consecutive grants: exactly 1 cycle with gnt = 0 (IDLE). Resource sees a clean handoff.
- Best-case back-to-back throughput: one new owner every 2 cycles.
- rst asserted mid-GRANT: gnt drops asynchronously. After deassertion the arbiter restarts at IDLE with last = 15.

## Structure
- Package arb_pkg: N_REQ = 16, ID_W = 4, state_t enum {IDLE, GRANT}.
- Sub-module: the team's existing or16 instance computes any_req from req. The priority search is a local function (rotate, find-first-set, rotate back).
- Arbiter RTL is a single always_ff plus a combinational next-owner block.

## Test plan
- Reset: hold rst high with req = 16'hFFFF -> gnt = 0, gnt_valid = 0, gnt_id = 0. Release rst with req = 16'h0000 -> outputs stay 0 indefinitely.
- Single requester: req = 16'h0020 for 3 cycles then 0 -> gnt = 16'h0020, gnt_id = 5 from cycle after first sample, held 3 cycles, cleared the cycle after req drops.
- Round-robin fairness: req = 16'hFFFF, each grantee drops req for 1 cycle after 2 cycles of grant -> grant order 0,1,2,…,15,0 with one idle cycle between grants.
- Wrap-around: last grant id = 14, then req = 16'h0009 -> next grant id 0, then 3 (not 3 first).
- Forced release (MAX_HOLD = 4): req = 16'h0101 held constant -> gnt = 16'h0001 for exactly 4 cycles, 1 idle, 16'h0100 for 4 cycles, 1 idle, 16'h0001 again.
- Reset mid-grant: assert rst while gnt = 16'h0400 -> gnt = 0 within the same cycle without a clock edge. After release with req = 16'h0401 -> first grant is id 0.
